// File: rtl/next_pc_unit.sv
// Registered fetch-stage next-PC generator with stall handling, deferred
// exceptions and a circular return-address stack.
module next_pc_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_4180,
  parameter int unsigned RAS_DEPTH   = 4,
  parameter int unsigned LINK_OFFSET = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [2:0]  pc_source,
  input  logic [15:0] imm_16,
  input  logic [25:0] imm_26,
  input  logic [31:0] reg_target,
  input  logic [29:0] epc_in,
  input  logic        ras_push,
  output logic [29:0] pc_out,
  output logic        ras_empty,
  output logic        ras_full,
  output logic        ras_miss,
  output logic        exc_pending
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Depth   = CntW'(RAS_DEPTH);
  localparam logic [29:0]     LinkOff = 30'(LINK_OFFSET);

  localparam logic [2:0] SrcAdd   = 3'd1;
  localparam logic [2:0] SrcJ     = 3'd2;
  localparam logic [2:0] SrcJr    = 3'd3;
  localparam logic [2:0] SrcEpc   = 3'd4;
  localparam logic [2:0] SrcError = 3'd5;
  localparam logic [2:0] SrcRas   = 3'd6;

  typedef enum logic [0:0] {StRun, StExcPend} state_e;

  state_e            state_q, state_d;
  logic [29:0]       pc_q, pc_d;
  logic [PtrW-1:0]   top_q, top_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              miss_q, miss_d;
  logic [29:0]       ras_mem [RAS_DEPTH];
  logic              wr_en;
  logic [PtrW-1:0]   wr_ptr;
  logic [29:0]       wr_data;
  logic              ras_has_entry;
  logic              pop_req;
  logic              unused_bits;

  assign ras_has_entry = (cnt_q != '0);
  assign pop_req       = (pc_source == SrcRas);
  assign wr_data       = pc_q + LinkOff;
  assign unused_bits   = ^reg_target[1:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    top_d   = top_q;
    cnt_d   = cnt_q;
    miss_d  = 1'b0;
    wr_en   = 1'b0;
    wr_ptr  = top_q;
    case (state_q)
      StRun: begin
        if (stall) begin
          // Only an exception survives a stall; everything else is re-presented.
          if (pc_source == SrcError) state_d = StExcPend;
        end else begin
          case (pc_source)
            SrcAdd:   pc_d = pc_q + {{14{imm_16[15]}}, imm_16};
            SrcJ:     pc_d = {pc_q[29:26], imm_26};
            SrcJr:    pc_d = reg_target[31:2];
            SrcEpc:   pc_d = epc_in;
            SrcError: pc_d = EXC_VECTOR[31:2];
            SrcRas: begin
              if (ras_has_entry) begin
                pc_d = ras_mem[top_q];
              end else begin
                pc_d   = reg_target[31:2];
                miss_d = 1'b1;
              end
            end
            default:  pc_d = pc_q + 30'd1;
          endcase
          if (pop_req && ras_has_entry && ras_push) begin
            // Pop and push cancel: replace the top entry in place.
            wr_en  = 1'b1;
            wr_ptr = top_q;
          end else if (pop_req && ras_has_entry) begin
            top_d = top_q - PtrW'(1);
            cnt_d = cnt_q - CntW'(1);
          end else if (ras_push) begin
            wr_en  = 1'b1;
            wr_ptr = top_q + PtrW'(1);
            top_d  = top_q + PtrW'(1);
            if (cnt_q != Depth) cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StExcPend: begin
        if (!stall) begin
          pc_d    = EXC_VECTOR[31:2];
          state_d = StRun;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      pc_q    <= RESET_PC[31:2];
      top_q   <= '0;
      cnt_q   <= '0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      top_q   <= top_d;
      cnt_q   <= cnt_d;
      miss_q  <= miss_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) ras_mem[wr_ptr] <= wr_data;
  end

  assign pc_out      = pc_q;
  assign ras_empty   = (cnt_q == '0);
  assign ras_full    = (cnt_q == Depth);
  assign ras_miss    = miss_q;
  assign exc_pending = (state_q == StExcPend);

endmodule
